// File: rtl/ntt_mem_loader.sv
// rtl/ntt_mem_loader.sv - scatters streamed coefficients across N banks of coefficient memory
// Coefficient k goes to bank k mod N, row base + k div N (optionally skewed by bank index).
module ntt_mem_loader #(
    parameter int N  = 257,
    parameter int AW = 8,
    parameter int W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW-1:0]        base,
    input  logic [AW:0]          nrows,
    input  logic                 rotate,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [W-1:0]         s_data,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         mem_we,
    output logic [N-1:0][AW-1:0] mem_addr,
    output logic [N-1:0][W-1:0]  mem_din
);
    localparam int BW = $clog2(N);
    localparam logic [BW-1:0] B_LAST = BW'(N - 1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);
    localparam logic [AW:0]   R_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        b_q, b_d;
    logic [AW:0]          r_q, r_d;
    logic [AW:0]          nrows_q, nrows_d;
    logic [AW-1:0]        base_q, base_d;
    logic                 rotate_q, rotate_d;
    logic [N-1:0]         mem_we_q, mem_we_d;
    logic [N-1:0][AW-1:0] mem_addr_q, mem_addr_d;
    logic [N-1:0][W-1:0]  mem_din_q, mem_din_d;
    logic [AW-1:0]        row_base;

    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        r_d        = r_q;
        nrows_d    = nrows_q;
        base_d     = base_q;
        rotate_d   = rotate_q;
        mem_we_d   = '0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        row_base   = base_q + r_q[AW-1:0];
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = base;
                    nrows_d  = (nrows == '0) ? R_ONE : nrows;
                    rotate_d = rotate;
                    b_d      = '0;
                    r_d      = '0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) begin
                    mem_we_d  = N'(1) << b_q;
                    mem_din_d = {N{s_data}};
                    // Every bank gets its own row address so a skewed layout needs no extra pass.
                    for (int j = 0; j < N; j++) begin
                        mem_addr_d[j] = row_base + (rotate_q ? AW'(j) : AW'(0));
                    end
                    if (b_q == B_LAST) begin
                        b_d = '0;
                        if (r_q == nrows_q - R_ONE) begin
                            state_d = ST_DONE;
                        end else begin
                            r_d = r_q + R_ONE;
                        end
                    end else begin
                        b_d = b_q + B_ONE;
                    end
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            b_q        <= '0;
            r_q        <= '0;
            nrows_q    <= '0;
            base_q     <= '0;
            rotate_q   <= 1'b0;
            mem_we_q   <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            r_q        <= r_d;
            nrows_q    <= nrows_d;
            base_q     <= base_d;
            rotate_q   <= rotate_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
endmodule

// File: tb/tb_ntt_mem_loader.sv
// tb/tb_ntt_mem_loader.sv - scoreboard bench for ntt_mem_loader
// Driver pushes expected writes/done cycles; a negedge monitor pops and compares.
module tb_ntt_mem_loader;
    localparam int N  = 257;
    localparam int AW = 8;
    localparam int W  = 32;

    logic                 clk = 1'b0;
    logic                 rst, start, rotate, s_valid, s_ready, busy, done;
    logic [AW-1:0]        base;
    logic [AW:0]          nrows;
    logic [W-1:0]         s_data;
    logic [N-1:0]         mem_we;
    logic [N-1:0][AW-1:0] mem_addr;
    logic [N-1:0][W-1:0]  mem_din;

    ntt_mem_loader #(.N(N), .AW(AW), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .nrows(nrows),
        .rotate(rotate), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .busy(busy), .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            bank;
        logic [AW-1:0] row;
        logic [AW-1:0] row0;
        logic [W-1:0]  data;
    } wr_t;

    wr_t          wr_q[$];
    int           done_q[$];
    logic [W-1:0] dvec[$];
    logic [W-1:0] tbmem [N][256];
    logic [W-1:0] snap  [N][256];
    int checks = 0, failures = 0, cyc = 0, done_cnt = 0, exp_done = 0;
    bit prev_acc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: consumes the scoreboard whenever the DUT presents a write or done.
    always @(negedge clk) begin
        wr_t          e;
        logic [N-1:0] exp_we;
        if (rst) begin
            prev_acc = 1'b0;
        end else begin
            chk("we_iff_prev_accept", {63'b0, |mem_we}, {63'b0, prev_acc});
            if (|mem_we) begin
                chk("write_expected", wr_q.size() > 0, 1);
                if (wr_q.size() > 0) begin
                    e = wr_q.pop_front();
                    exp_we = '0;
                    exp_we[e.bank] = 1'b1;
                    chk("we_onehot_bank", mem_we === exp_we, 1);
                    chk("addr_bank", mem_addr[e.bank], e.row);
                    chk("addr_bank0", mem_addr[0], e.row0);
                    chk("din_bank", mem_din[e.bank], e.data);
                    chk("din_broadcast", mem_din[N-1], e.data);
                end
                for (int j = 0; j < N; j++)
                    if (mem_we[j]) tbmem[j][mem_addr[j]] = mem_din[j];
            end
            if (done) begin
                done_cnt++;
                chk("done_expected", done_q.size() > 0, 1);
                if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
            end
            prev_acc = s_valid && s_ready;
        end
    end

    task automatic clear_mem();
        for (int b = 0; b < N; b++)
            for (int r = 0; r < 256; r++) tbmem[b][r] = 32'hDEADBEEF;
    endtask

    task automatic gen_data(input bit rnd, input int total);
        dvec.delete();
        for (int k = 0; k < total; k++) dvec.push_back(rnd ? $urandom : W'(k));
    endtask

    task automatic check_mem(input logic [AW-1:0] b0, input int nre, input bit rot);
        for (int k = 0; k < N * nre; k++) begin
            int bank = k % N;
            int r    = k / N;
            int row  = (b0 + r + (rot ? bank : 0)) % 256;
            chk("mem_contents", tbmem[bank][row], dvec[k]);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", |mem_we, 0);
        chk("rst_addr", |mem_addr, 0);
        chk("rst_din", |mem_din, 0);
        @(posedge clk); #1 rst = 1'b0;
        wr_q.delete();
        done_q.delete();
    endtask

    task automatic run_load(input logic [AW-1:0] b0, input int nr, input bit rot,
                            input int gap, input int abort_at, input int start_at);
        int nre    = (nr == 0) ? 1 : nr;
        int total  = N * nre;
        int k      = 0;
        int budget = total * 4 + 200;
        int dc;
        bit acc;
        clear_mem();
        start = 1'b1; base = b0; nrows = nr[AW:0]; rotate = rot;
        @(posedge clk); #1 start = 1'b0;
        chk("start_ready", s_ready, 1);
        chk("start_busy", busy, 1);
        while (k < total && budget > 0 && k != abort_at) begin
            s_valid = ($urandom_range(99) >= gap);
            s_data  = dvec[k];
            start   = (k == start_at);
            if (start) base = $urandom;
            @(negedge clk);
            acc = s_valid && s_ready;
            if (acc) begin
                wr_t e;
                e.bank = k % N;
                e.row0 = AW'(b0 + k / N);
                e.row  = AW'(b0 + k / N + (rot ? k % N : 0));
                e.data = dvec[k];
                wr_q.push_back(e);
                if (k == total - 1) done_q.push_back(cyc + 1);
            end
            @(posedge clk); #1;
            if (acc) k++;
            budget--;
        end
        s_valid = 1'b0; start = 1'b0;
        if (k == abort_at) begin
            repeat (2) @(posedge clk);
            #1 dc = done_cnt;
            do_reset();
            repeat (20) @(posedge clk);
            #1 chk("abort_no_done", done_cnt, dc);
            chk("abort_busy", busy, 0);
            chk("abort_no_pending", wr_q.size(), 0);
        end else begin
            chk("load_completed", k, total);
            if (k != total) begin
                do_reset();
            end else begin
                exp_done++;
                @(posedge clk); #1;
                chk("idle_busy", busy, 0);
                chk("idle_ready", s_ready, 0);
                chk("writes_drained", wr_q.size(), 0);
                check_mem(b0, nre, rot);
            end
        end
    endtask

    initial begin
        logic [AW-1:0] rb;
        bit            rr;
        rst = 1'b1; start = 1'b0; base = '0; nrows = '0; rotate = 1'b0;
        s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", s_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_we", |mem_we, 0);
        chk("reset_addr", |mem_addr, 0);
        chk("reset_din", |mem_din, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        gen_data(1'b0, N);
        run_load(8'd0, 1, 1'b0, 0, -1, -1);
        chk("basic_done_count", done_cnt, 1);

        gen_data(1'b0, 3 * N);
        run_load(8'd254, 3, 1'b0, 0, -1, -1);
        chk("wrap_b5_r254", tbmem[5][254], 5);
        chk("wrap_b5_r255", tbmem[5][255], 262);
        chk("wrap_b5_r0", tbmem[5][0], 519);

        gen_data(1'b0, 2 * N);
        run_load(8'd0, 2, 1'b1, 0, -1, -1);
        chk("rot_b3_r3", tbmem[3][3], 3);
        chk("rot_b256_r1", tbmem[256][1], 513);

        gen_data(1'b1, 2 * N);
        rb = $urandom; rr = $urandom_range(1);
        run_load(rb, 2, rr, 0, -1, -1);
        snap = tbmem;
        run_load(rb, 2, rr, 50, -1, 60);
        for (int k = 0; k < 2 * N; k++) begin
            int row = (rb + k / N + (rr ? k % N : 0)) % 256;
            chk("bp_same_as_gapfree", tbmem[k % N][row], snap[k % N][row]);
        end

        gen_data(1'b1, N);
        run_load(AW'($urandom), 0, 1'($urandom_range(1)), 30, -1, -1);

        gen_data(1'b1, 2 * N);
        run_load(8'd37, 2, 1'b1, 20, 100, -1);

        for (int i = 0; i < 3; i++) begin
            int nr = $urandom_range(3, 1);
            gen_data(1'b1, nr * N);
            run_load(AW'($urandom), nr, 1'($urandom_range(1)), $urandom_range(60), -1, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("total_done_pulses", done_cnt, exp_done);
        chk("final_wr_queue", wr_q.size(), 0);
        chk("final_done_queue", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ntt_mem_loader.md
# ntt_mem_loader

Streams input coefficients into the banked coefficient memory that feeds the 257-point NTT datapath. It scatters coefficient k to bank k mod N, row k div N. It can optionally rotate the row address per bank so that later column accesses are conflict-free. It sits directly upstream of the N-bank memory and drives that memory's per-bank write-enable, address and data vectors.

## Interface
- N, 257, number of memory banks (one coefficient per bank per row)
- AW, 8, bank address width (bank depth 2^AW = 256)
- W, 32, coefficient width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load when idle
- base  in  AW  starting row address, sampled at start
- nrows  in  AW+1  rows to load, 1..256, sampled at start; 0 is treated as 1
- rotate  in  1  sampled at start; 1 = per-bank skewed row address
- s_valid  in  1  input coefficient valid
- s_ready  out  1  loader accepts a coefficient this cycle
- s_data  in  W  input coefficient
- busy  out  1  load in progress
- done  out  1  one-cycle pulse after the final write is issued
- mem_we  out  [N-1:0]  per-bank write enable, at most one bit set
- mem_addr  out  [N-1:0][AW-1:0]  per-bank row address
- mem_din  out  [N-1:0][W-1:0]  per-bank write data

## Operation
- The FSM has three states: IDLE, LOAD and DONE.
- **IDLE:** s_ready=0 and busy=0.
  - start=1 latches base, nrows and rotate.
  - It clears the bank counter b (0..N-1) and the row counter r (0..nrows-1), then goes to LOAD.
- **LOAD:** s_ready=1 and busy=1.
  - A beat is accepted when s_valid && s_ready.
  - On accept, b increments. When b=N-1, b wraps to 0 and r increments.
  - The beat that is accepted with b=N-1 and r=nrows-1 is the final beat. The FSM then goes to DONE.
  - Cycles with no accept leave all counters unchanged. There is no timeout.
- **DONE:** busy=1, s_ready=0 and done=1 for exactly one cycle, then back to IDLE.
- start is ignored outside IDLE.
- Row address for bank j:
  - rotate=0: base + r, modulo 2^AW.
  - rotate=1: base + r + j, modulo 2^AW.
  - Truncation to AW bits is natural; wrap past row 255 is legal and silent.
- Write issue for each accepted beat at (b, r):
  - mem_we[b]=1 and all other bits 0.
  - mem_din of every bank = s_data (broadcast). Only the enabled bank writes.
  - mem_addr of every bank j = row address for (j, r).
- When no beat is being written, mem_we=0. mem_addr and mem_din hold their last values.
- Counter widths: b is ceil(log2 N) bits (9 for N=257). r is AW+1 bits.
- The controller issues no reads. The memory's read port is observed only by downstream logic after done.

## Timing
- **Reset values:** state=IDLE, s_ready=0, busy=0, done=0, mem_we=0, mem_addr all 0, mem_din all 0, counters 0.
- **Reset mid-load:** the load aborts immediately. No further writes are issued and no done pulse occurs. Rows already written keep their contents.
- **start at cycle t** (in IDLE): s_ready=1 and busy=1 from cycle t+1.
- **Beat accepted at cycle t:** mem_we, mem_addr and mem_din show that write during cycle t+1 (one registered stage). The memory captures it on the edge ending t+1.
- **Final beat accepted at cycle t:** s_ready=0 from t+1. The final write is presented in t+1, and done=1 in t+1. IDLE is reached at t+2.
- **start at t+2:** a new load begins. Back-to-back loads lose a minimum of 2 cycles.
- **Throughput:** one coefficient per cycle. A full 256-row load takes 257·256 = 65792 accept cycles.
- **s_valid while s_ready=0:** ignored. The producer must hold the data.

## Test plan
- **Basic load:** rst, then start with base=0, nrows=1, rotate=0. Stream 257 beats with data=k.
  - Required: bank k row 0 holds k.
  - Required: done pulses exactly once, 1 cycle after the 257th accept.
  - Required: mem_we is one-hot on every write cycle.
- **Row wrap:** base=254, nrows=3, rotate=0, data=k.
  - Required: bank 5 holds 5 at row 254, 262 at row 255, and 519 at row 0.
- **Rotate:** base=0, nrows=2, rotate=1.
  - Required: coefficient 3 lands in bank 3 row 3.
  - Required: coefficient 257+256=513 lands in bank 256 row 1 (1+256 mod 256).
- **Backpressure:** random s_valid gaps, about 50%, with nrows=2.
  - Required: the memory contents are identical to the gap-free run.
  - Required: no mem_we in cycles after a non-accept cycle.
  - Required: the done cycle equals the last accept + 1.
- **Abort and ignore:**
  - Assert rst after 100 beats. Required: all outputs are 0 immediately and no done pulse occurs.
  - Pulse start during LOAD. Required: counters are unaffected.
  - Run with nrows=0. Required: the load behaves as nrows=1.
